message_checker: RTL
====================

Name: message_checker

Overview:
- Reads the decrypted-message RAM back after the PRGA/decrypt stage has written it, one byte at a time.
- Checks that every byte is a legal plaintext character: lowercase a–z (0x61–0x7A) or space (0x20).
- Reports pass/fail and the index of the first bad byte to the controller FSM, which uses the verdict to accept the key or step to the next one.
- It is the reader end of the decrypted-message RAM interface.

Parameters:
- MESSAGE_LENGTH, 32: number of bytes checked, at addresses 0..MESSAGE_LENGTH-1. Legal range 1..256.
- RAM_LATENCY, 1: clock cycles from address to valid q. Legal range 1..4.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level request from the controller; sampled only in IDLE.
- finish  out  1  one-cycle pulse when the verdict is ready.
- q  in  8  read data from the decrypted-message RAM.
- address  out  8  RAM read address. It is 8'h00 whenever not in ADDR/WAIT/CHECK, because addresses from several masters are ORed onto the shared bus.
- busy  out  1  high in every state except IDLE.
- pass  out  1  verdict: 1 means all bytes are legal. Held until the next start is accepted.
- fail_index  out  8  index of the first illegal byte; 8'h00 on pass. Held until the next start is accepted.

Behaviour:
- Reset values: address=0, finish=0, busy=0, pass=0, fail_index=0, byte counter i=0, wait counter=0. State goes to IDLE.
- This block never writes the RAM and has no wren output.
- IDLE:
  - start=1 → ADDR, with i=0.
  - On acceptance, pass and fail_index clear to 0.
- ADDR:
  - Drive address=i.
  - Load the wait counter with RAM_LATENCY-1, then → WAIT.
- WAIT:
  - address stays at i.
  - Decrement the counter; at 0 → CHECK.
- CHECK:
  - address stays at i; q now holds byte i.
  - Illegal byte → DONE with pass=0, fail_index=i. The check aborts early.
  - Legal byte and i==MESSAGE_LENGTH-1 → DONE with pass=1.
  - Otherwise i increments → ADDR.
- DONE:
  - finish=1 for exactly this cycle; address=0.
  - → IDLE unconditionally.
- Cycles per byte = 2+RAM_LATENCY.
- Latency on an all-legal message: finish is high in cycle MESSAGE_LENGTH*(2+RAM_LATENCY)+1 after the cycle start was sampled. This is 97 cycles for the defaults.
- Latency on failure at index k: finish is high in cycle (k+1)*(2+RAM_LATENCY)+1.
- Counter width is 9 bits internally, so MESSAGE_LENGTH=256 terminates on i==255 without wrapping. address is i[7:0].
- start while busy: ignored, no restart.
- start held high through DONE: the IDLE cycle after DONE samples it and begins a new check. The controller deasserts start on finish.
- reset mid-operation: next cycle is IDLE with all outputs at reset values. No finish pulse is produced.
- Legality boundaries:
  - 0x20, 0x61 and 0x7A are legal.
  - 0x1F, 0x21, 0x60, 0x7B, 0x00 and 0xFF are illegal.

Optional Feature:
- Macro: MESSAGE_CHECKER_UPPERCASE_EN.
- When defined: 0x41–0x5A (A–Z) are also legal. Boundaries are 0x40 illegal, 0x41 legal, 0x5A legal, 0x5B illegal.
- When undefined: uppercase letters are illegal and the legal set is exactly as in Behaviour.
- Timing and the interface are identical either way.

Decomposition:
- Shared package rc4_pkg holds:
  - the checker state enum (IDLE, ADDR, WAIT, CHECK, DONE);
  - character constants CHAR_SPACE=8'h20, CHAR_LOWER_A=8'h61, CHAR_LOWER_Z=8'h7A, CHAR_UPPER_A=8'h41, CHAR_UPPER_Z=8'h5A;
  - MSG_ADDR_W=8.
- One sub-module, char_validator: combinational, 8-bit input to 1-bit is_legal output. The macro is applied inside it only.

Test Plan:
- RAM holds 32 bytes of "attack at dawn" padded with spaces; pulse start → finish at cycle 97, pass=1, fail_index=0, address returns to 0.
- Byte 5 = 0x7B, others legal → finish at cycle 19, pass=0, fail_index=5. Addresses 6+ are never driven.
- Byte 0 = 0x41 → macro undefined: pass=0, fail_index=0, finish at cycle 4. Macro defined: pass=1.
- RAM_LATENCY=3, MESSAGE_LENGTH=4, all 0x20 → finish at cycle 21, pass=1. Each address is held for 5 cycles.
- Assert reset in cycle 10 of a run → next cycle is IDLE, busy=0, address=0, and finish never pulses. A fresh start then completes normally.
- start held high throughout a run → single finish per run, the run is not restarted while busy, and a second run begins the cycle after DONE.

Source files
------------

// File: rtl/rc4_pkg.sv
// rc4_pkg: shared checker state encoding, plaintext character bounds and message address width.
package rc4_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } checker_state_t;

    localparam logic [7:0] CHAR_SPACE   = 8'h20;
    localparam logic [7:0] CHAR_LOWER_A = 8'h61;
    localparam logic [7:0] CHAR_LOWER_Z = 8'h7A;
    localparam logic [7:0] CHAR_UPPER_A = 8'h41;
    localparam logic [7:0] CHAR_UPPER_Z = 8'h5A;

    localparam int MSG_ADDR_W = 8;

endpackage

// File: rtl/message_checker_char_validator.sv
// char_validator: flags space and a-z as legal; MESSAGE_CHECKER_UPPERCASE_EN also admits A-Z.
import rc4_pkg::*;

module char_validator (
    input  logic [7:0] ch,
    output logic       is_legal
);

`ifdef MESSAGE_CHECKER_UPPERCASE_EN
    assign is_legal = (ch == CHAR_SPACE) ||
                      (ch >= CHAR_LOWER_A && ch <= CHAR_LOWER_Z) ||
                      (ch >= CHAR_UPPER_A && ch <= CHAR_UPPER_Z);
`else
    assign is_legal = (ch == CHAR_SPACE) ||
                      (ch >= CHAR_LOWER_A && ch <= CHAR_LOWER_Z);
`endif

endmodule

// File: rtl/message_checker.sv
// message_checker: reads the decrypted-message RAM and reports the first illegal byte (MESSAGE_CHECKER_UPPERCASE_EN widens the legal set).
import rc4_pkg::*;

module message_checker #(
    parameter int MESSAGE_LENGTH = 32,
    parameter int RAM_LATENCY    = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  finish,
    input  logic [7:0]            q,
    output logic [MSG_ADDR_W-1:0] address,
    output logic                  busy,
    output logic                  pass,
    output logic [7:0]            fail_index
);

    localparam logic [1:0] WAIT_INIT = 2'(RAM_LATENCY - 1);
    // Nine bits so a 256-byte message ends on i==255 without wrapping.
    localparam logic [8:0] LAST_I = 9'(MESSAGE_LENGTH - 1);

    checker_state_t state;
    logic [8:0]     i;
    logic [1:0]     wait_cnt;
    logic           is_legal;

    char_validator u_char_validator (
        .ch       (q),
        .is_legal (is_legal)
    );

    // The address bus is ORed with other masters, so it must read zero when idle.
    assign address = (state == ADDR || state == WAIT || state == CHECK) ? i[7:0] : '0;
    assign busy    = state != IDLE;
    assign finish  = state == DONE;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            i          <= '0;
            wait_cnt   <= '0;
            pass       <= 1'b0;
            fail_index <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state      <= ADDR;
                    i          <= '0;
                    pass       <= 1'b0;
                    fail_index <= '0;
                end
                ADDR: begin
                    wait_cnt <= WAIT_INIT;
                    state    <= WAIT;
                end
                WAIT: if (wait_cnt == '0) state <= CHECK;
                      else wait_cnt <= wait_cnt - 2'd1;
                CHECK: if (!is_legal) begin
                    state      <= DONE;
                    pass       <= 1'b0;
                    fail_index <= i[7:0];
                end else if (i == LAST_I) begin
                    state <= DONE;
                    pass  <= 1'b1;
                end else begin
                    i     <= i + 9'd1;
                    state <= ADDR;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
